// File: rtl/des_pkg.sv
// Shared definitions for the DES frame loader.
// Holds the loader FSM state encoding, the frame layout constants and the
// block width used by the keyIn/desIn ports.
package des_pkg;

    // Block width of the controller's key and plaintext words
    localparam int unsigned BLOCK_W     = 64;

    // Frame layout: key bytes first, then plaintext bytes
    localparam int unsigned FRAME_BYTES = 16;
    localparam int unsigned KEY_BYTES   = 8;

    // Loader FSM state encoding
    localparam logic [1:0] ST_COLLECT   = 2'd0;
    localparam logic [1:0] ST_SETTLE    = 2'd1;
    localparam logic [1:0] ST_PULSE     = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/des_frame_loader.sv
// Upstream frame loader for the DES encryption controller.
// Collects 8 key bytes then 8 plaintext bytes from a byte stream, presents
// them as keyIn/desIn, raises start after a settle period, then waits for the
// controller's ready (with timeout) before accepting the next frame.
//
// Ports:
//   clk, rst      - clock (rising edge), asynchronous active-high reset
//   byte_valid    - byte_data valid this cycle
//   byte_data     - stream byte, bit 7 lands in the lowest-numbered word bit
//   byte_ready    - loader accepts a byte this cycle (combinational)
//   frame_abort   - discard the partially collected frame
//   des_ready     - controller ready / encryption complete
//   keyIn, desIn  - key and plaintext words, [1:64] MSB-first
//   start         - start pulse to controller
//   busy          - high while an operation is in flight
//   done          - one-cycle completion pulse
//   timeout_err   - sticky timeout flag, cleared by next frame's first byte
module des_frame_loader
    import des_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned START_LEN   = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    input  logic             frame_abort,
    input  logic             des_ready,
    output logic [1:BLOCK_W] keyIn,
    output logic [1:BLOCK_W] desIn,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int unsigned MAX_A   = (SETTLE_CYC > START_LEN) ? SETTLE_CYC : START_LEN;
    localparam int unsigned CNT_MAX = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:BLOCK_W]   key_sh_q, key_sh_d;
    logic [1:BLOCK_W]   dat_sh_q, dat_sh_d;
    logic [1:BLOCK_W]   key_q, key_d;
    logic [1:BLOCK_W]   dat_q, dat_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               terr_q, terr_d;
    logic               saw_q, saw_d;
    logic [6:0]         ins_pos;

    assign byte_ready  = (state_q == ST_COLLECT) && !frame_abort;
    assign busy        = (state_q != ST_COLLECT);
    assign keyIn       = key_q;
    assign desIn       = dat_q;
    assign start       = start_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

    // Bit position of byte k within its 64-bit half: 8*(k mod 8) + 1
    assign ins_pos = {1'b0, bcnt_q[2:0], 3'b000} + 7'd1;

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        cnt_d    = cnt_q;
        key_sh_d = key_sh_q;
        dat_sh_d = dat_sh_q;
        key_d    = key_q;
        dat_d    = dat_q;
        start_d  = 1'b0;
        done_d   = 1'b0;
        terr_d   = terr_q;
        saw_d    = saw_q;

        case (state_q)
            ST_COLLECT: begin
                if (frame_abort) begin
                    bcnt_d = '0;
                end else if (byte_valid) begin
                    if (bcnt_q == '0) begin
                        terr_d = 1'b0;
                    end
                    if (bcnt_q < 4'(KEY_BYTES)) begin
                        key_sh_d[ins_pos +: 8] = byte_data;
                    end else begin
                        dat_sh_d[ins_pos +: 8] = byte_data;
                    end
                    if (bcnt_q == 4'(FRAME_BYTES - 1)) begin
                        // Outputs take the shadow including the byte inserted this cycle
                        key_d   = key_sh_d;
                        dat_d   = dat_sh_d;
                        bcnt_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    saw_d   = 1'b0;
                    start_d = 1'b1;
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PULSE: begin
                saw_d = saw_q | !des_ready;
                if (cnt_q == CNT_W'(START_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else begin
                    start_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                saw_d = saw_q | !des_ready;
                // Ready only counts once it has been seen low since start rose
                if (des_ready && saw_q) begin
                    done_d  = 1'b1;
                    state_d = ST_COLLECT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    terr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_COLLECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_COLLECT;
            bcnt_q   <= '0;
            cnt_q    <= '0;
            key_sh_q <= '0;
            dat_sh_q <= '0;
            key_q    <= '0;
            dat_q    <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
            saw_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            cnt_q    <= cnt_d;
            key_sh_q <= key_sh_d;
            dat_sh_q <= dat_sh_d;
            key_q    <= key_d;
            dat_q    <= dat_d;
            start_q  <= start_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
            saw_q    <= saw_d;
        end
    end

endmodule

// File: doc/des_frame_loader.md
Name: des_frame_loader

Overview:
- Upstream feeder for the DES encryption controller.
- Collects a 16-byte frame from a byte stream: 8 key bytes, then 8 plaintext bytes.
- Presents the frame as 64-bit keyIn/desIn words, generates the controller's start pulse, then waits for the controller's ready before accepting the next frame.
- Holds keyIn/desIn stable for the whole operation, because the controller re-latches its inputs whenever start is low.

Parameters:
- SETTLE_CYC, 2: cycles keyIn/desIn are held with start low before start rises (min 1).
- START_LEN, 4: cycles start is held high (min 2).
- TIMEOUT_CYC, 1024: maximum WAIT_DONE cycles before abandoning the operation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- byte_valid  in  1  byte_data valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- frame_abort  in  1  discard the partially collected frame.
- des_ready  in  1  controller ready (encryption complete).
- keyIn  out  [1:64]  key to controller.
- desIn  out  [1:64]  plaintext to controller.
- start  out  1  start pulse to controller.
- busy  out  1  high in SETTLE, PULSE and WAIT_DONE.
- done  out  1  one-cycle pulse when the controller reports completion.
- timeout_err  out  1  sticky; set on timeout, cleared when the next frame's first byte is accepted.

Behaviour:
- Single clock domain; reset is asynchronous and active-high.
- Reset values: state=COLLECT, byte count=0, keyIn=0, desIn=0, start=0, done=0, timeout_err=0, busy=0.
- Reset asserted mid-operation forces start low immediately.
- byte_ready = (state==COLLECT) && !frame_abort (combinational).
- Accept: byte_valid && byte_ready on a rising clk edge.
- Byte index k uses a 4-bit counter, 0..15.
- k=0..7 go to shadow key bits [8k+1 : 8k+8]; k=8..15 go to shadow data bits [8(k-8)+1 : 8(k-8)+8].
- byte_data[7] maps to the lowest-numbered bit (MSB-first, matching the controller's [1:64] ordering).
- Shadow registers are internal. keyIn/desIn outputs change only on the cycle the 16th byte is accepted: shadow plus last byte are copied out, and the state goes to SETTLE.
- FSM states:
  - COLLECT:
    - frame_abort clears the byte count; no byte is accepted that cycle (abort wins over a simultaneous byte_valid).
    - Accepting byte 15 sets count to 0 and the state to SETTLE.
  - SETTLE:
    - start=0; counter runs SETTLE_CYC cycles, then goes to PULSE.
    - frame_abort is ignored.
  - PULSE:
    - start=1 for exactly START_LEN cycles, then goes to WAIT_DONE.
    - A clear-on-entry flag saw_low is set on any cycle where des_ready==0.
  - WAIT_DONE:
    - start=0; saw_low keeps updating.
    - If des_ready==1 && saw_low: done=1 for one cycle, state goes to COLLECT.
    - Otherwise, if the wait counter reaches TIMEOUT_CYC-1: timeout_err=1, state goes to COLLECT, no done pulse.
- saw_low guards against a des_ready left high by the previous operation. The controller drops ready within 2 cycles of the start edge, hence START_LEN >= 2.
- Latency:
  - From the accept of byte 15 to start rising = SETTLE_CYC+1 cycles.
  - done follows the first qualifying des_ready high by 1 cycle (registered).
- The first byte of a new frame may be accepted in the cycle after done.
- A new frame's bytes are never accepted while busy; upstream back-pressure is required.

Decomposition:
- Shared package des_pkg holds:
  - loader state encoding (COLLECT, SETTLE, PULSE, WAIT_DONE);
  - FRAME_BYTES=16, KEY_BYTES=8;
  - the 64-bit block width constant.
- Single module, no sub-module. Counters and the shift/insert logic stay inline.

Test Plan:
- Key/data load:
  - Stimulus: reset, then bytes 13 34 57 79 9B BC DF F1 01 23 45 67 89 AB CD EF, one per cycle, des_ready tied 0.
  - Required: keyIn=64'h133457799BBCDFF1 and desIn=64'h0123456789ABCDEF on the cycle after the last accept; start low 2 cycles, then high exactly 4; byte_ready=0 from then on.
- Full encryption:
  - Stimulus: same frame against the real controller.
  - Required: done pulses once after ready rises; controller desOut=64'h85E813540F0AB405; keyIn/desIn unchanged throughout busy.
- Stale ready:
  - Stimulus: des_ready held 1 during SETTLE and PULSE, dropped to 0 for 1 cycle in PULSE, raised in WAIT_DONE.
  - Required: no done pulse before the drop; done exactly 1 cycle after the re-rise.
- Abort:
  - Stimulus: 5 bytes, then frame_abort together with byte_valid, then a full 16-byte frame.
  - Required: the abort-cycle byte is not accepted (byte_ready=0); outputs reflect only the 16-byte frame.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16, des_ready stuck 0.
  - Required: timeout_err=1 after 16 WAIT_DONE cycles; no done pulse; byte_ready=1 next cycle; timeout_err clears on the next first byte.
- Reset mid-PULSE:
  - Stimulus: assert rst asynchronously while start=1.
  - Required: start, keyIn, desIn and busy go to 0 immediately; byte_ready=1 after release.
